// File: rtl/glitch_pulser.sv
// Glitch pulse-train generator: armed by firmware, triggered by reset-done, then emits
// N pulses of W high cycles separated by G low cycles after a D+1 cycle delay.
module glitch_pulser #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic             trigger_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic [CNT_W-1:0] gap_i,
  input  logic [REP_W-1:0] count_i,
  output logic             glitch_o,
  output logic             armed_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] S_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] S_ARMED = 3'd1;
  localparam logic [ST_W-1:0] S_DELAY = 3'd2;
  localparam logic [ST_W-1:0] S_PULSE = 3'd3;
  localparam logic [ST_W-1:0] S_GAP   = 3'd4;

  logic [ST_W-1:0]  state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [REP_W-1:0] pcnt_q, pcnt_n;
  logic [CNT_W-1:0] dly_q, wid_last_q, gap_last_q;
  logic [REP_W-1:0] num_last_q;
  logic             latch_c;
  logic             done_n;

  // Zero-substituted terminal counts: a programmed 0 behaves as 1, i.e. last index 0
  logic [CNT_W-1:0] wid_last_c, gap_last_c;
  logic [REP_W-1:0] num_last_c;

  assign wid_last_c = (width_i == '0) ? '0 : width_i - CNT_W'(1);
  assign gap_last_c = (gap_i   == '0) ? '0 : gap_i   - CNT_W'(1);
  assign num_last_c = (count_i == '0) ? '0 : count_i - REP_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    pcnt_n  = pcnt_q;
    latch_c = 1'b0;
    done_n  = 1'b0;
    if (abort_i) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      pcnt_n  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm_i) state_n = S_ARMED;
        end
        S_ARMED: begin
          // Trigger beats a simultaneous arm drop
          if (trigger_i) begin
            latch_c = 1'b1;
            state_n = S_DELAY;
            cnt_n   = '0;
            pcnt_n  = '0;
          end else if (!arm_i) begin
            state_n = S_IDLE;
          end
        end
        S_DELAY: begin
          if (cnt_q == dly_q) begin
            state_n = S_PULSE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        S_PULSE: begin
          if (cnt_q == wid_last_q) begin
            cnt_n = '0;
            if (pcnt_q == num_last_q) begin
              state_n = S_IDLE;
              pcnt_n  = '0;
              done_n  = 1'b1;
            end else begin
              state_n = S_GAP;
              pcnt_n  = pcnt_q + REP_W'(1);
            end
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_q == gap_last_q) begin
            state_n = S_PULSE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
          pcnt_n  = '0;
        end
      endcase
    end
  end

  // Counters and train parameters captured on the accepting trigger
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      pcnt_q     <= '0;
      dly_q      <= '0;
      wid_last_q <= '0;
      gap_last_q <= '0;
      num_last_q <= '0;
    end else begin
      cnt_q  <= cnt_n;
      pcnt_q <= pcnt_n;
      if (latch_c) begin
        dly_q      <= delay_i;
        wid_last_q <= wid_last_c;
        gap_last_q <= gap_last_c;
        num_last_q <= num_last_c;
      end
    end
  end

  // Outputs decoded from next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_o <= 1'b0;
      armed_o  <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      glitch_o <= (state_n == S_PULSE);
      armed_o  <= (state_n == S_ARMED);
      busy_o   <= (state_n == S_DELAY) || (state_n == S_PULSE) || (state_n == S_GAP);
      done_o   <= done_n;
    end
  end

endmodule

// File: tb/tb_glitch_pulser.sv
// Directed bench for glitch_pulser: per-cycle output traces after a trigger are
// compared against hand-computed bit vectors (bit t = value after edge k+t).
module tb_glitch_pulser;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm_i;
  logic        abort_i;
  logic        trigger_i;
  logic [15:0] delay_i;
  logic [15:0] width_i;
  logic [15:0] gap_i;
  logic [7:0]  count_i;
  logic        glitch_o;
  logic        armed_o;
  logic        busy_o;
  logic        done_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] v_glitch, v_busy, v_done, v_armed;

  glitch_pulser #(.CNT_W(16), .REP_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .arm_i     (arm_i),
    .abort_i   (abort_i),
    .trigger_i (trigger_i),
    .delay_i   (delay_i),
    .width_i   (width_i),
    .gap_i     (gap_i),
    .count_i   (count_i),
    .glitch_o  (glitch_o),
    .armed_o   (armed_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int count_rises(input logic [31:0] v);
    int r = 0;
    for (int i = 1; i < 32; i++) if (v[i] && !v[i-1]) r++;
    return r;
  endfunction

  // Called at a negedge while ARMED; trigger is sampled on the following edge (k+1)
  task automatic run_train(input logic [15:0] d, input logic [15:0] w, input logic [15:0] g,
                           input logic [7:0] n, input int abort_at, input bit disturb);
    delay_i   = d;
    width_i   = w;
    gap_i     = g;
    count_i   = n;
    trigger_i = 1'b1;
    v_glitch  = '0;
    v_busy    = '0;
    v_done    = '0;
    v_armed   = '0;
    v_glitch[0] = glitch_o;
    v_busy[0]   = busy_o;
    v_done[0]   = done_o;
    v_armed[0]  = armed_o;
    for (int t = 1; t < 32; t++) begin
      @(negedge clk);
      v_glitch[t] = glitch_o;
      v_busy[t]   = busy_o;
      v_done[t]   = done_o;
      v_armed[t]  = armed_o;
      trigger_i = 1'b0;
      if (disturb && t == 2) begin
        trigger_i = 1'b1;
        delay_i   = 16'd9;
      end
      abort_i = (t == abort_at);
    end
    abort_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arm_i = 1'b0; abort_i = 1'b0; trigger_i = 1'b0;
    delay_i = '0; width_i = '0; gap_i = '0; count_i = '0;
    repeat (3) @(negedge clk);
    check("rst_glitch", 32'(glitch_o), 32'd0);
    check("rst_armed",  32'(armed_o),  32'd0);
    check("rst_busy",   32'(busy_o),   32'd0);
    check("rst_done",   32'(done_o),   32'd0);
    rst = 1'b0;
    arm_i = 1'b1;
    @(negedge clk);
    check("arm_armed", 32'(armed_o), 32'd1);

    // D=4 W=3 N=1 G=7 with a second trigger and delay change during DELAY
    run_train(16'd4, 16'd3, 16'd7, 8'd1, -1, 1'b1);
    check("t1_glitch", v_glitch, 32'h0000_01C0);
    check("t1_busy",   v_busy,   32'h0000_01FE);
    check("t1_done",   v_done,   32'h0000_0200);
    check("t1_armed",  v_armed,  32'hFFFF_FC01);

    // All-zero programming exercises zero substitution
    run_train(16'd0, 16'd0, 16'd0, 8'd0, -1, 1'b0);
    check("t2_glitch", v_glitch, 32'h0000_0004);
    check("t2_busy",   v_busy,   32'h0000_0006);
    check("t2_done",   v_done,   32'h0000_0008);
    check("t2_armed",  v_armed,  32'hFFFF_FFF1);

    // Three-pulse train
    run_train(16'd2, 16'd2, 16'd3, 8'd3, -1, 1'b0);
    check("t3_glitch", v_glitch, 32'h0000_C630);
    check("t3_busy",   v_busy,   32'h0000_FFFE);
    check("t3_done",   v_done,   32'h0001_0000);
    check("t3_armed",  v_armed,  32'hFFFE_0001);
    check("t3_rises",  32'(count_rises(v_glitch)), 32'd3);

    // Abort sampled at edge k+5, in the first pulse
    run_train(16'd2, 16'd2, 16'd3, 8'd3, 4, 1'b0);
    check("ab_glitch", v_glitch, 32'h0000_0010);
    check("ab_busy",   v_busy,   32'h0000_001E);
    check("ab_done",   v_done,   32'h0000_0000);
    check("ab_armed",  v_armed,  32'hFFFF_FFC1);

    // Trigger while IDLE is ignored
    arm_i = 1'b0;
    @(negedge clk);
    check("idle_armed", 32'(armed_o), 32'd0);
    trigger_i = 1'b1;
    @(negedge clk);
    trigger_i = 1'b0;
    check("idle_trig_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    check("idle_trig_busy2", 32'(busy_o), 32'd0);

    // Abort and trigger together: abort wins, then level arm re-arms
    arm_i = 1'b1;
    @(negedge clk);
    check("rearm_armed", 32'(armed_o), 32'd1);
    abort_i = 1'b1; trigger_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0; trigger_i = 1'b0;
    check("abtrig_busy",  32'(busy_o),  32'd0);
    check("abtrig_armed", 32'(armed_o), 32'd0);
    @(negedge clk);
    check("abtrig_rearm", 32'(armed_o), 32'd1);

    // Arm drop with trigger in the same cycle: train starts
    delay_i = 16'd4; width_i = 16'd3; gap_i = 16'd7; count_i = 8'd1;
    arm_i = 1'b0; trigger_i = 1'b1;
    @(negedge clk);
    trigger_i = 1'b0;
    check("armdrop_busy",  32'(busy_o),  32'd1);
    check("armdrop_armed", 32'(armed_o), 32'd0);
    repeat (5) @(negedge clk);
    check("mid_glitch", 32'(glitch_o), 32'd1);

    // Reset mid-pulse
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_glitch", 32'(glitch_o), 32'd0);
    check("midrst_busy",   32'(busy_o),   32'd0);
    @(negedge clk);
    check("midrst_done",   32'(done_o),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
